// File: rtl/range_scheduler.sv
// rtl/range_scheduler.sv - round-robin ultrasonic rangefinder sequencer with cm conversion
module range_scheduler #(
  parameter int N_SENSORS    = 4,
  parameter int TRIG_CYCLES  = 500,
  parameter int CM_DIV       = 2900,
  parameter int ECHO_TIMEOUT = 1450000,
  parameter int GUARD_CYCLES = 3000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] chan_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic [8:0]           dist_cm,
  output logic [1:0]           dist_chan,
  output logic                 dist_timeout,
  output logic                 dist_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;

  localparam logic [31:0] TRIG_LAST  = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] DIV_LAST   = 32'(CM_DIV - 1);
  localparam logic [31:0] TO_LAST    = 32'(ECHO_TIMEOUT - 1);
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam int          TO_CM_RAW  = ECHO_TIMEOUT / CM_DIV;
  localparam logic [8:0]  TO_CM      = (TO_CM_RAW > 511) ? 9'd511 : 9'(TO_CM_RAW);
  localparam logic [1:0]  LAST_INIT  = 2'(N_SENSORS - 1);

  state_t                 state, next_state;
  logic [N_SENSORS-1:0]   echo_meta, echo_sync;
  logic [1:0]             cur, last, pick, rr_idx, trig_sel;
  logic                   found;
  logic [31:0]            cnt, sub, sub_next;
  logic [8:0]             cm, cm_next;
  logic                   es, start;
  logic [N_SENSORS-1:0]   trig_next;

  assign es    = echo_sync[cur];
  assign start = enable && (|chan_mask);

  // two-flop synchroniser for the asynchronous echo lines
  always_ff @(posedge clock) begin
    if (reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // round-robin: first eligible channel strictly after the last one served
  always_comb begin
    pick   = last;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= N_SENSORS; k++) begin
      rr_idx = 2'((int'(last) + k) % N_SENSORS);
      if (!found && chan_mask[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // one echo-high cycle worth of distance: sub-counter wraps into a saturating cm count
  always_comb begin
    sub_next = sub + 32'd1;
    cm_next  = cm;
    if (sub == DIV_LAST) begin
      sub_next = '0;
      if (cm != 9'd511) cm_next = cm + 9'd1;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = TRIG;
      TRIG:      if (cnt == TRIG_LAST) next_state = WAIT_RISE;
      WAIT_RISE: begin
        if (es)                   next_state = MEASURE;
        else if (cnt == TO_LAST)  next_state = GUARD;
      end
      MEASURE: begin
        if (!es)                  next_state = GUARD;
        else if (cnt == TO_LAST)  next_state = GUARD;
      end
      GUARD:     if (cnt == GUARD_LAST) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // trigger line for the next cycle, registered so trig never glitches
  always_comb begin
    trig_next = '0;
    trig_sel  = (state == IDLE) ? pick : cur;
    if (next_state == TRIG) trig_next[trig_sel] = 1'b1;
  end

  // ping datapath: counters, channel bookkeeping and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      trig         <= '0;
      cur          <= '0;
      last         <= LAST_INIT;
      cnt          <= '0;
      sub          <= '0;
      cm           <= '0;
      dist_cm      <= '0;
      dist_chan    <= '0;
      dist_timeout <= 1'b0;
      dist_valid   <= 1'b0;
    end else begin
      trig       <= trig_next;
      dist_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur <= pick;
            cnt <= '0;
            sub <= '0;
            cm  <= '0;
          end
        end
        TRIG: begin
          if (cnt == TRIG_LAST) cnt <= '0;
          else                  cnt <= cnt + 32'd1;
        end
        WAIT_RISE: begin
          if (es) begin
            // the rise cycle is itself the first measured echo-high cycle
            cnt <= '0;
            sub <= sub_next;
            cm  <= cm_next;
          end else if (cnt == TO_LAST) begin
            cnt          <= '0;
            dist_valid   <= 1'b1;
            dist_chan    <= cur;
            last         <= cur;
            dist_cm      <= TO_CM;
            dist_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        MEASURE: begin
          if (!es) begin
            cnt          <= '0;
            dist_valid   <= 1'b1;
            dist_chan    <= cur;
            last         <= cur;
            dist_cm      <= cm;
            dist_timeout <= 1'b0;
          end else if (cnt == TO_LAST) begin
            cnt          <= '0;
            dist_valid   <= 1'b1;
            dist_chan    <= cur;
            last         <= cur;
            dist_cm      <= TO_CM;
            dist_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
            sub <= sub_next;
            cm  <= cm_next;
          end
        end
        GUARD: begin
          cnt <= cnt + 32'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_range_scheduler.sv
// tb/tb_range_scheduler.sv - directed self-checking bench for range_scheduler
module tb_range_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] chan_mask;
  logic [3:0] echo;
  logic [3:0] trig;
  logic [8:0] dist_cm;
  logic [1:0] dist_chan;
  logic       dist_timeout;
  logic       dist_valid;
  logic       busy;

  int tests = 0;
  int fails = 0;

  range_scheduler #(
    .N_SENSORS(4),
    .TRIG_CYCLES(10),
    .CM_DIV(29),
    .ECHO_TIMEOUT(290),
    .GUARD_CYCLES(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .chan_mask(chan_mask),
    .echo(echo),
    .trig(trig),
    .dist_cm(dist_cm),
    .dist_chan(dist_chan),
    .dist_timeout(dist_timeout),
    .dist_valid(dist_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one ping on channel ch with an echo of width cycles, expecting exp_cm
  task automatic ping(input int ch, input int width, input int exp_cm);
    int n;
    n = 0;
    while (trig == 4'b0000 && n < 200) begin tick(); n++; end
    check("rr_trig_chan", 32'(trig), 32'(4'b0001 << ch));
    n = 0;
    while (trig != 4'b0000 && n < 50) begin tick(); n++; end
    check("rr_trig_len", 32'(n), 32'd10);
    repeat (5) tick();
    echo = 4'(4'b0001 << ch);
    repeat (width) tick();
    echo = 4'b0000;
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    check("rr_fall_to_valid", 32'(n), 32'd3);
    check("rr_dist_cm", 32'(dist_cm), 32'(exp_cm));
    check("rr_dist_chan", 32'(dist_chan), 32'(ch));
    check("rr_dist_timeout", 32'(dist_timeout), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    reset     = 1'b1;
    enable    = 1'b0;
    chan_mask = 4'b0000;
    echo      = 4'b0000;
    repeat (3) tick();
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(dist_valid), 32'd0);
    check("rst_cm", 32'(dist_cm), 32'd0);
    check("rst_chan", 32'(dist_chan), 32'd0);
    check("rst_timeout", 32'(dist_timeout), 32'd0);

    // reset while a ping on channel 1 is triggering
    chan_mask = 4'b0010;
    enable    = 1'b1;
    reset     = 1'b0;
    tick();
    check("trig_ch1_start", 32'(trig), 32'd2);
    check("busy_in_trig", 32'(busy), 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset_trig_drop", 32'(trig), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_no_valid", 32'(dist_valid), 32'd0);
    chan_mask = 4'b0001;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_ch0", 32'(trig), 32'd1);

    // nominal ping on channel 0: echo 290 cycles -> 10 cm
    n = 0;
    while (trig != 4'b0000 && n < 50) begin tick(); n++; end
    check("nom_trig_len", 32'(n), 32'd10);
    repeat (20) tick();
    echo = 4'b0001;
    repeat (290) tick();
    echo = 4'b0000;
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    check("nom_fall_to_valid", 32'(n), 32'd3);
    check("nom_cm", 32'(dist_cm), 32'd10);
    check("nom_chan", 32'(dist_chan), 32'd0);
    check("nom_timeout", 32'(dist_timeout), 32'd0);
    tick();
    n = 1;
    check("nom_valid_pulse", 32'(dist_valid), 32'd0);
    check("nom_cm_hold", 32'(dist_cm), 32'd10);
    while (trig == 4'b0000 && n < 200) begin tick(); n++; end
    check("nom_guard_gap", 32'(n), 32'd51);
    check("nom_single_chan_again", 32'(trig), 32'd1);

    // round robin over mask 1011 (mask only takes effect in IDLE)
    chan_mask = 4'b1011;
    ping(0, 58, 2);
    ping(1, 29, 1);
    ping(3, 28, 0);
    ping(0, 87, 3);
    ping(1, 145, 5);
    ping(3, 200, 6);

    // no echo on channel 1
    chan_mask = 4'b0010;
    n = 0;
    while (trig == 4'b0000 && n < 200) begin tick(); n++; end
    check("noecho_trig", 32'(trig), 32'd2);
    n = 0;
    while (trig != 4'b0000 && n < 50) begin tick(); n++; end
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    check("noecho_latency", 32'(n), 32'd290);
    check("noecho_cm", 32'(dist_cm), 32'd10);
    check("noecho_timeout", 32'(dist_timeout), 32'd1);
    check("noecho_chan", 32'(dist_chan), 32'd1);

    // stuck-high echo on channel 2
    chan_mask = 4'b0101;
    echo      = 4'b0100;
    n = 0;
    while (trig == 4'b0000 && n < 200) begin tick(); n++; end
    check("stuck_trig", 32'(trig), 32'd4);
    n = 0;
    while (trig != 4'b0000 && n < 50) begin tick(); n++; end
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    check("stuck_latency", 32'(n), 32'd291);
    check("stuck_timeout", 32'(dist_timeout), 32'd1);
    check("stuck_cm", 32'(dist_cm), 32'd10);
    check("stuck_chan", 32'(dist_chan), 32'd2);
    echo = 4'b0000;
    n = 0;
    while (trig == 4'b0000 && n < 200) begin tick(); n++; end
    check("stuck_advance_ch0", 32'(trig), 32'd1);

    // enable and mask dropped mid-measurement
    n = 0;
    while (trig != 4'b0000 && n < 50) begin tick(); n++; end
    repeat (5) tick();
    echo = 4'b0001;
    repeat (10) tick();
    enable    = 1'b0;
    chan_mask = 4'b0000;
    repeat (50) tick();
    echo = 4'b0000;
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    check("drop_fall_to_valid", 32'(n), 32'd3);
    check("drop_cm", 32'(dist_cm), 32'd2);
    check("drop_chan", 32'(dist_chan), 32'd0);
    check("drop_timeout", 32'(dist_timeout), 32'd0);
    repeat (49) tick();
    check("drop_guard_busy", 32'(busy), 32'd1);
    tick();
    check("drop_idle_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trig != 4'b0000 || busy || dist_valid) seen = 1'b1;
    end
    check("drop_stays_idle", 32'(seen), 32'd0);
    check("drop_cm_hold", 32'(dist_cm), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
